// File: rtl/ucsbece154b_victim_pkg.sv
// Shared types for the victim-cache miss controller: FSM states and fill-source encoding.
package ucsbece154b_victim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StProbe,
        StMemReq,
        StMemWait,
        StFill,
        StDrain
    } state_e;

    typedef enum logic {
        FILL_VC  = 1'b0,
        FILL_MEM = 1'b1
    } fill_src_e;

    // Number of byte-offset bits inside one cache line.
    function automatic int unsigned line_offset_bits(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ucsbece154b_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ucsbece154b_victim_ctrl.sv
// L1 miss controller: probes the victim cache, writes back the L1 eviction, falls back to memory,
// and returns exactly one fill per accepted miss.
module ucsbece154b_victim_ctrl
    import ucsbece154b_victim_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  fill_src_o,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    input  logic                  vc_hit_i,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    localparam int unsigned OffsetBits = line_offset_bits(LINE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LineMask = {ADDR_WIDTH{1'b1}} << OffsetBits;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic                  evict_valid_q;
    logic [ADDR_WIDTH-1:0] evict_addr_q;
    logic [LINE_WIDTH-1:0] evict_data_q;
    logic [LINE_WIDTH-1:0] fill_data_q;
    fill_src_e             fill_src_q;

    logic hit_inc, miss_inc;

    assign vc_en_o    = ~rst_i;
    assign vc_flush_o = rst_i | flush_i;

    // A same-cycle flush cancels whatever the current state would present.
    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        vc_raddr_o      = '0;
        vc_we_o         = 1'b0;
        vc_waddr_o      = '0;
        vc_wdata_o      = '0;
        fill_valid_o    = 1'b0;
        fill_addr_o     = '0;
        fill_data_o     = '0;
        fill_src_o      = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StIdle: miss_ready_o = ~flush_i;
                StProbe: begin
                    vc_raddr_o = miss_addr_q;
                    if (evict_valid_q && !flush_i) begin
                        vc_we_o    = 1'b1;
                        vc_waddr_o = evict_addr_q;
                        vc_wdata_o = evict_data_q;
                    end
                end
                StMemReq: begin
                    if (!flush_i) begin
                        mem_req_valid_o = 1'b1;
                        mem_req_addr_o  = miss_addr_q & LineMask;
                    end
                end
                StFill: begin
                    if (!flush_i) begin
                        fill_valid_o = 1'b1;
                        fill_addr_o  = miss_addr_q;
                        fill_data_o  = fill_data_q;
                        fill_src_o   = fill_src_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hit_inc  = !rst_i && !flush_i && (state_q == StProbe) && vc_hit_i;
    assign miss_inc = mem_req_valid_o && mem_req_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            miss_addr_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            fill_data_q   <= '0;
            fill_src_q    <= FILL_VC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_valid_i && miss_ready_o) begin
                        miss_addr_q   <= miss_addr_i;
                        evict_valid_q <= evict_valid_i;
                        evict_addr_q  <= evict_addr_i;
                        evict_data_q  <= evict_data_i;
                        state_q       <= StProbe;
                    end
                end
                StProbe: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (vc_hit_i) begin
                        fill_data_q <= vc_rdata_i;
                        fill_src_q  <= FILL_VC;
                        state_q     <= StFill;
                    end else begin
                        state_q <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (mem_req_ready_i) begin
                        state_q <= StMemWait;
                    end
                end
                StMemWait: begin
                    // A response landing with the flush is the one DRAIN would wait for.
                    if (flush_i) begin
                        state_q <= mem_rsp_valid_i ? StIdle : StDrain;
                    end else if (mem_rsp_valid_i) begin
                        fill_data_q <= mem_rsp_data_i;
                        fill_src_q  <= FILL_MEM;
                        state_q     <= StFill;
                    end
                end
                StFill: state_q <= StIdle;
                StDrain: begin
                    if (mem_rsp_valid_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ucsbece154b_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_hit_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (hit_inc),
        .cnt_o (hit_cnt_o)
    );

    ucsbece154b_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_miss_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (miss_inc),
        .cnt_o (miss_cnt_o)
    );

endmodule

// File: doc/ucsbece154b_victim_ctrl.md
UCSBECE154B_VICTIM_CTRL -- requirements
Module: ucsbece154b_victim_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 56, the byte address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, the cache line width in bits.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, the statistics counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i input 1, the clock; rst_i input 1, synchronous active-high reset.
REQ-005 SHALL have the following L1 miss ports: flush_i input 1, flush request; miss_valid_i input 1, L1 miss pending; miss_ready_o output 1, miss accepted; miss_addr_i input ADDR_WIDTH, miss address.
REQ-006 SHALL have the following L1 eviction ports: evict_valid_i input 1, L1 evicts a valid line; evict_addr_i input ADDR_WIDTH, evicted address; evict_data_i input LINE_WIDTH, evicted line.
REQ-007 SHALL have the following L1 fill ports: fill_valid_o output 1, fill pulse; fill_addr_o output ADDR_WIDTH, fill address; fill_data_o output LINE_WIDTH, fill data; fill_src_o output 1, source of the fill (0 = victim cache, 1 = memory).
REQ-008 SHALL have the following victim-cache ports: vc_en_o output 1; vc_flush_o output 1; vc_raddr_o output ADDR_WIDTH; vc_rdata_i input LINE_WIDTH; vc_hit_i input 1, combinational hit; vc_we_o output 1; vc_waddr_o output ADDR_WIDTH; vc_wdata_o output LINE_WIDTH.
REQ-009 SHALL have the following memory ports: mem_req_valid_o output 1; mem_req_ready_i input 1; mem_req_addr_o output ADDR_WIDTH; mem_rsp_valid_i input 1; mem_rsp_data_i input LINE_WIDTH.
REQ-010 SHALL have the following statistics ports: hit_cnt_o output CNT_WIDTH, victim-cache hits; miss_cnt_o output CNT_WIDTH, memory fetches.

Function
REQ-011 SHALL implement the FSM states IDLE, PROBE, MEM_REQ, MEM_WAIT, FILL and DRAIN.
REQ-012 SHALL assert miss_ready_o only in IDLE; on miss_valid_i && miss_ready_o it SHALL latch miss_addr_i, evict_valid_i, evict_addr_i and evict_data_i, and go to PROBE.
REQ-013 In PROBE it SHALL drive vc_raddr_o = latched miss address and, when the latched evict_valid is set, drive vc_we_o = 1 with vc_waddr_o and vc_wdata_o set to the latched eviction, all in the same cycle.
REQ-014 In PROBE with vc_hit_i = 1 it SHALL capture vc_rdata_i, set fill_src = 0, increment hit_cnt and go to FILL; on a miss it SHALL go to MEM_REQ.
REQ-015 In MEM_REQ it SHALL hold mem_req_valid_o = 1 and mem_req_addr_o = the miss address aligned to the line; on mem_req_ready_i it SHALL increment miss_cnt and go to MEM_WAIT.
REQ-016 In MEM_WAIT, on mem_rsp_valid_i it SHALL capture mem_rsp_data_i, set fill_src = 1 and go to FILL.
REQ-017 FILL SHALL assert fill_valid_o for exactly one cycle with the registered address, data and source, then return to IDLE; the fill has no backpressure.
REQ-018 Latency: a victim-cache hit SHALL produce fill_valid_o 2 cycles after acceptance; a memory fill SHALL produce it 1 cycle after mem_rsp_valid_i.
REQ-019 A victim-cache hit SHALL NOT invalidate the victim entry; duplicate clean lines are permitted.
REQ-020 vc_en_o SHALL be 1 whenever rst_i = 0; vc_flush_o SHALL equal rst_i | flush_i (combinational).
REQ-021 flush_i in IDLE, PROBE, MEM_REQ or FILL SHALL cause the next state to be IDLE with no fill and no victim-cache write; in PROBE the same-cycle vc_we_o SHALL be suppressed.
REQ-022 flush_i in MEM_WAIT SHALL go to DRAIN; DRAIN SHALL wait for mem_rsp_valid_i, discard the data and return to IDLE; miss_ready_o SHALL remain 0 during DRAIN.
REQ-023 mem_rsp_valid_i outside MEM_WAIT and DRAIN SHALL be ignored.
REQ-024 The counters SHALL saturate at all-ones and are not cleared by flush_i.
REQ-025 All outputs not explicitly driven in a state SHALL be 0.

Reset
REQ-026 On rst_i the FSM SHALL go to IDLE, all latched registers and both counters SHALL clear to 0, and fill_valid_o, mem_req_valid_o, vc_we_o and miss_ready_o SHALL be 0 during reset.
REQ-027 A reset asserted mid-transaction SHALL abandon the transaction with no DRAIN; the memory side is reset by the same rst_i.

Structure
REQ-028 The package ucsbece154b_victim_pkg SHALL hold the FSM state enum and the fill-source enum (FILL_VC, FILL_MEM).
REQ-029 Sub-module ucsbece154b_sat_counter (parameter WIDTH, inputs inc_i and clr_i) SHALL be instantiated twice, once for each statistic.

Verification
REQ-030 Hit path: preload the victim cache with 0x1000 -> D; miss 0x1000 with evict 0x2000 -> E. Required: vc_we_o in cycle 1 with waddr 0x2000; fill_valid_o in cycle 2 with data D, src 0; hit_cnt_o = 1.
REQ-031 Miss path: miss 0x3000, mem_req_ready_i delayed 3 cycles, response M 4 cycles later. Required: a single mem request at 0x3000; fill of M with src 1 one cycle after the response; miss_cnt_o = 1.
REQ-032 Flush in MEM_WAIT: flush_i, then the response arrives 5 cycles later. Required: vc_flush_o pulses; no fill_valid_o; miss_ready_o = 0 until the cycle after the response.
REQ-033 Flush in PROBE with an eviction pending. Required: vc_we_o = 0, no fill, IDLE on the next cycle.
REQ-034 Back-to-back misses with the second miss_valid_i held high. Required: the second miss is accepted the cycle after the first FILL, and both fills are in order.
REQ-035 Counter saturation with CNT_WIDTH = 2 and 5 hits. Required: hit_cnt_o = 3.
